lif_neuron_array: RTL and testbench

//  Receiving end of the spike-gated weight row path: accepts packed, spike-gated 16-bit

---
 rtl/snn_pkg.sv | 23 ++
 rtl/lif_cell.sv | 65 ++++++
 rtl/lif_neuron_array.sv | 95 +++++++++
 tb/tb_lif_neuron_array.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and helpers for the spiking layer: weight width, saturation, FSM encoding.
package snn_pkg;

  localparam int WEIGHT_W = 16;
  localparam logic signed [WEIGHT_W-1:0] DEF_THRESH = 16'sd1000;
  localparam int DEF_LEAK_SHIFT = 4;

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_LEAK = 2'd1,
    ST_FIRE = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // A 17-bit sum overflowed exactly when its top two bits disagree.
  function automatic logic signed [WEIGHT_W-1:0] sat16(input logic signed [WEIGHT_W:0] s);
    if (s[WEIGHT_W] != s[WEIGHT_W-1])
      return s[WEIGHT_W] ? 16'sh8000 : 16'sh7FFF;
    else
      return s[WEIGHT_W-1:0];
  endfunction

endpackage

// File: rtl/lif_cell.sv
// One LIF neuron: membrane register, refractory counter, saturating integrate, leak, fire test.
// Strobes come from the array FSM; spike_o is the combinational fire decision for FIRE.
module lif_cell
  import snn_pkg::*;
#(
  parameter logic signed [WEIGHT_W-1:0] THRESH     = DEF_THRESH,
  parameter logic signed [WEIGHT_W-1:0] V_RESET    = 16'sd0,
  parameter int                         LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int                         REFRAC     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       acc_en_i,
  input  logic                       leak_en_i,
  input  logic                       fire_en_i,
  input  logic signed [WEIGHT_W-1:0] w_i,
  output logic signed [WEIGHT_W-1:0] v_o,
  output logic                       spike_o
);

  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

  logic signed [WEIGHT_W-1:0] v_q, v_d;
  logic [RW-1:0]              refr_q, refr_d;
  logic signed [WEIGHT_W:0]   sum;
  logic signed [WEIGHT_W-1:0] leak_v;
  logic                       refr_zero;
  logic                       fire;

  assign refr_zero = (refr_q == '0);
  assign sum       = {v_q[WEIGHT_W-1], v_q} + {w_i[WEIGHT_W-1], w_i};
  // v - (v >>> k) moves toward zero by less than |v|, so it cannot overflow.
  assign leak_v    = v_q - (v_q >>> LEAK_SHIFT);
  assign fire      = refr_zero && (v_q >= THRESH);
  assign spike_o   = fire;
  assign v_o       = v_q;

  always_comb begin
    v_d    = v_q;
    refr_d = refr_q;
    if (acc_en_i && refr_zero)
      v_d = sat16(sum);
    if (leak_en_i)
      v_d = leak_v;
    if (fire_en_i) begin
      if (fire) begin
        v_d    = V_RESET;
        refr_d = RW'(REFRAC);
      end else if (!refr_zero) begin
        refr_d = refr_q - RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= V_RESET;
      refr_q <= '0;
    end else begin
      v_q    <= v_d;
      refr_q <= refr_d;
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// N-neuron LIF array: integrates spike-gated weight rows, emits one spike vector per timestep.
// step_end sampled -> OUT two edges later; OUT holds until out_ready, in_ready low outside ACC.
module lif_neuron_array
  import snn_pkg::*;
#(
  parameter int                         N          = 3,
  parameter logic signed [WEIGHT_W-1:0] THRESH     = DEF_THRESH,
  parameter logic signed [WEIGHT_W-1:0] V_RESET    = 16'sd0,
  parameter int                         LEAK_SHIFT = DEF_LEAK_SHIFT,
  parameter int                         REFRAC     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WEIGHT_W*N-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  step_end,
  output logic [N-1:0]          out_spikes,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WEIGHT_W*N-1:0] v_mon
);

  state_t       state_q;
  logic         in_ready_q;
  logic         out_valid_q;
  logic [N-1:0] out_spikes_q;
  logic [N-1:0] fire_vec;
  logic         beat;
  logic         leak_en;
  logic         fire_en;

  assign beat       = in_valid && in_ready_q;
  assign leak_en    = (state_q == ST_LEAK);
  assign fire_en    = (state_q == ST_FIRE);
  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_spikes = out_spikes_q;

  // Neuron 0 sits in the most significant lane of every bus.
  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    lif_cell #(
      .THRESH    (THRESH),
      .V_RESET   (V_RESET),
      .LEAK_SHIFT(LEAK_SHIFT),
      .REFRAC    (REFRAC)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .acc_en_i (beat),
      .leak_en_i(leak_en),
      .fire_en_i(fire_en),
      .w_i      (in_data[WEIGHT_W*(N-gi)-1 -: WEIGHT_W]),
      .v_o      (v_mon[WEIGHT_W*(N-gi)-1 -: WEIGHT_W]),
      .spike_o  (fire_vec[N-1-gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ACC;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_spikes_q <= '0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (step_end) begin
            state_q    <= ST_LEAK;
            in_ready_q <= 1'b0;
          end
        end
        ST_LEAK: state_q <= ST_FIRE;
        ST_FIRE: begin
          state_q      <= ST_OUT;
          out_valid_q  <= 1'b1;
          out_spikes_q <= fire_vec;
        end
        ST_OUT: begin
          if (out_ready) begin
            state_q     <= ST_ACC;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_ACC;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed bench for lif_neuron_array: arithmetic reference model plus literal spot checks.
module tb_lif_neuron_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        step_end = 1'b0;
  logic [2:0]  out_spikes;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [47:0] v_mon;

  lif_neuron_array dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .step_end  (step_end),
    .out_spikes(out_spikes),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .v_mon     (v_mon)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: membrane values, refractory counts, expected handshake levels.
  int       mv[3];
  int       mr[3];
  bit       m_valid;
  bit       m_ready;
  bit [2:0] m_spk;
  bit       chk_en = 1'b0;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic int vmon(int i);
    return int'($signed(v_mon[47-16*i -: 16]));
  endfunction

  function automatic int sat(int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int leak(int v);
    return v - (v >>> 4);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      mv[i] = 0;
      mr[i] = 0;
    end
    m_valid = 1'b0;
    m_ready = 1'b1;
    m_spk   = '0;
  endtask

  task automatic m_leak();
    for (int i = 0; i < 3; i++) mv[i] = leak(mv[i]);
  endtask

  task automatic m_fire();
    for (int i = 0; i < 3; i++) begin
      if (mr[i] == 0 && mv[i] >= 1000) begin
        m_spk[2-i] = 1'b1;
        mv[i] = 0;
        mr[i] = 2;
      end else begin
        m_spk[2-i] = 1'b0;
        if (mr[i] > 0) mr[i]--;
      end
    end
    m_valid = 1'b1;
    m_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) chk($sformatf("cmp_v%0d", i), vmon(i), mv[i]);
      chk("cmp_out_valid", int'(out_valid), int'(m_valid));
      chk("cmp_in_ready", int'(in_ready), int'(m_ready));
      if (m_valid) chk("cmp_out_spikes", int'(out_spikes), int'(m_spk));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit vld, int a, int b, int c, bit se);
    int  w[3];
    bit  acc;
    w[0] = a; w[1] = b; w[2] = c;
    in_data  = {16'(a), 16'(b), 16'(c)};
    in_valid = vld;
    step_end = se;
    tick();
    acc = m_ready;
    if (vld && acc)
      for (int i = 0; i < 3; i++)
        if (mr[i] == 0) mv[i] = sat(mv[i] + w[i]);
    if (se && acc) m_ready = 1'b0;
    in_valid = 1'b0;
    step_end = 1'b0;
  endtask

  // Beats and a step_end pulse offered while OUT is held must all be ignored.
  task automatic accept(int hold);
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      drive(1'b1, 7, 7, 7, k == 2);
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    m_valid = 1'b0;
    m_ready = 1'b1;
    out_ready = 1'b0;
  endtask

  task automatic timestep(int a, int b, int c);
    drive(1'b1, a, b, c, 1'b0);
    drive(1'b0, 0, 0, 0, 1'b1);
    tick(); m_leak();
    tick(); m_fire();
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #2;
    m_reset();
    for (int i = 0; i < 3; i++) chk($sformatf("rst_v%0d", i), vmon(i), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", int'(in_ready), 1);
  endtask

  initial begin
    m_reset();
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_en = 1'b1;
    chk("init_in_ready", int'(in_ready), 1);
    chk("init_out_valid", int'(out_valid), 0);
    chk("init_v0", vmon(0), 0);

    // Reset in the middle of accumulation
    drive(1'b1, 500, 0, 0, 1'b0);
    chk("t1_v0_pre", vmon(0), 500);
    reset_pulse();

    // Saturation and arithmetic-shift leak on negative values
    drive(1'b1, 32767, -32768, -100, 1'b0);
    drive(1'b1, 32767, -32768, -100, 1'b0);
    chk("t3_v0_sat", vmon(0), 32767);
    chk("t3_v1_sat", vmon(1), -32768);
    chk("t3_v2", vmon(2), -200);
    drive(1'b0, 0, 0, 0, 1'b1);
    tick(); m_leak();
    chk("t3_v0_leak", vmon(0), 30720);
    chk("t3_v1_leak", vmon(1), -30720);
    chk("t3_v2_leak", vmon(2), -187);
    tick(); m_fire();
    chk("t3_spikes", int'(out_spikes), 3'b100);
    accept(0);
    reset_pulse();

    // Basic fire with step_end-to-out_valid latency
    drive(1'b1, 600, 0, 0, 1'b0);
    drive(1'b1, 600, 0, 0, 1'b0);
    drive(1'b0, 0, 0, 0, 1'b1);
    chk("t2_valid_e1", int'(out_valid), 0);
    tick(); m_leak();
    chk("t2_v0_leak", vmon(0), 1125);
    chk("t2_valid_e2", int'(out_valid), 0);
    tick(); m_fire();
    chk("t2_valid_e3", int'(out_valid), 1);
    chk("t2_spikes", int'(out_spikes), 3'b100);
    chk("t2_v0_reset", vmon(0), 0);
    chk("t2_v1", vmon(1), 0);
    chk("t2_v2", vmon(2), 0);
    accept(0);

    // Refractory: two ignored timesteps, then the neuron fires again
    for (int t = 0; t < 3; t++) begin
      drive(1'b1, 2000, 0, 0, 1'b0);
      chk("t4_v0_acc", vmon(0), (t < 2) ? 0 : 2000);
      drive(1'b0, 0, 0, 0, 1'b1);
      tick(); m_leak();
      tick(); m_fire();
      chk("t4_spikes", int'(out_spikes), (t < 2) ? 0 : 4);
      accept(0);
    end

    // Backpressure in OUT
    timestep(0, 300, -50);
    chk("t5_spikes", int'(out_spikes), 0);
    chk("t5_v1", vmon(1), 282);
    chk("t5_v2", vmon(2), -46);
    accept(5);
    chk("t5_in_ready_after", int'(in_ready), 1);
    chk("t5_valid_after", int'(out_valid), 0);

    // Beat and step_end in the same cycle; step_end during OUT ignored
    reset_pulse();
    drive(1'b1, 1100, 0, 0, 1'b1);
    chk("t6_v0_int", vmon(0), 1100);
    tick(); m_leak();
    chk("t6_v0_leak", vmon(0), 1032);
    tick(); m_fire();
    chk("t6_spikes", int'(out_spikes), 3'b100);
    accept(3);
    for (int k = 0; k < 3; k++) drive(1'b0, 0, 0, 0, 1'b0);
    chk("t6_in_ready_stays", int'(in_ready), 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
